apb_master: RTL and testbench

APB requester that converts a simple valid/ready command stream into APB3 transfers and returns a response. It sits between the SoC's internal command source (processor-side bridge or test sequencer) and the APB peripheral bus, driving slaves such as the GPIO register block. It handles one transfer at a time, with an optional watchdog that terminates a transfer when a slave hangs.

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_timeout_cnt.sv | 31 +++
 rtl/apb_master.sv | 137 +++++++++++++
 tb/tb_apb_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester types: the transfer-phase enum, default bus widths
// and the packed response record used by APB requesters.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  err;
    logic [APB_DATA_W-1:0] rdata;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Stall counter for the APB ACCESS phase. Counts cycles spent waiting on
// PREADY and flags the cycle that would be the TIMEOUT_CYCLES-th stall.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // cnt_q holds the number of stalled ACCESS cycles already elapsed
  logic [CNT_W-1:0] cnt_q;

  // clear ahead of ACCESS, then step once per stalled cycle (saturating)
  always_ff @(posedge PCLK) begin
    if (PRESET || clear) begin
      cnt_q <= '0;
    end else if (count && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // current stalled cycle is the last one allowed
  assign expired = count && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one valid/ready command in, one APB transfer, one
// response out. Optional stall watchdog enabled by APB_MASTER_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL high, PENABLE low, exactly one cycle
// ACCESS | PSEL and PENABLE high, waiting for PREADY (or watchdog)
// RESP   | rsp_valid high, response held until rsp_ready
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  apb_state_e state_q, state_d;
  logic       accept, complete, abort, timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clear   (state_q == SETUP),
    .count   ((state_q == ACCESS) && !PREADY),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and phase-decoded outputs; PREADY beats the watchdog
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // APB request fields change only when a new command is taken
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

  // response capture; read data is zeroed for writes and any error
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (complete) begin
      rsp_err   <= PSLVERR;
      rsp_rdata <= (PWRITE || PSLVERR) ? '0 : PRDATA;
    end else if (abort) begin
      rsp_err   <= 1'b1;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed vector table, hand-written
// corner sequences and randomized transfers against a transfer-level model.
module tb_apb_master;

  localparam int TMO = 16;

  logic        PCLK, PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_g = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        serr;
    logic [31:0] sdata;
    int          hold;
    bit          keep;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge PCLK);
    #1;
    cyc_g++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transfer-level reference: latency from acceptance edge to first RESP cycle
  task automatic model(input logic wr, input int waits, input logic serr, input logic [31:0] sdata,
                       output int lat, output logic [31:0] rdata, output logic err);
`ifdef APB_MASTER_TIMEOUT_EN
    if (waits >= TMO) begin
      lat = 2 + TMO; rdata = 32'h0; err = 1'b1;
      return;
    end
`endif
    lat   = 3 + waits;
    err   = serr;
    rdata = (wr || serr) ? 32'h0 : sdata;
  endtask

  task automatic reset_checks();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
  endtask

  // one command with a reactive slave inserting `waits` stall cycles
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic serr, input logic [31:0] sdata,
                      input int hold, input bit keep, input int exp_lat,
                      input logic [31:0] exp_rdata, input logic exp_err, output int acc_cyc);
    int cyc, n_setup, n_access, t_rsp;
    bit got;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    acc_cyc   = cyc_g;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
    rsp_ready = 1'($urandom_range(0, 1));
    tick();
    cmd_valid = keep; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = $urandom;
    cyc = 1; n_setup = 0; n_access = 0; got = 0; t_rsp = 0;
    while (!got && cyc < 200) begin
      if (rsp_valid) begin
        got = 1; t_rsp = cyc;
      end else begin
        chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
        chk("psel_busy", 64'(PSEL), 64'(1));
        chk("paddr_hold", 64'(PADDR), 64'(addr));
        chk("pwrite_hold", 64'(PWRITE), 64'(wr));
        chk("pwdata_hold", 64'(PWDATA), 64'(wdata));
        if (PSEL && !PENABLE) n_setup++;
        if (PSEL && PENABLE) begin
          n_access++;
          if (n_access - 1 == waits) begin
            PREADY = 1'b1; PRDATA = sdata; PSLVERR = serr;
          end else begin
            PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
          end
        end else begin
          PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom;
        end
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
    end
    chk("rsp_seen", 64'(got), 64'(1));
    if (!got) begin
      PRESET = 1'b1; tick(); PRESET = 1'b0; cmd_valid = 1'b0;
      return;
    end
    chk("rsp_latency", 64'(t_rsp), 64'(exp_lat));
    chk("setup_cycles", 64'(n_setup), 64'(1));
    chk("access_cycles", 64'(n_access), 64'(exp_lat - 2));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("resp_psel", 64'(PSEL), 64'(0));
    chk("resp_penable", 64'(PENABLE), 64'(0));
    rsp_ready = (hold == 0);
    for (int h = 1; h <= hold; h++) begin
      PREADY = 1'($urandom_range(0, 1)); PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      tick();
      chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("hold_psel", 64'(PSEL), 64'(0));
      rsp_ready = (h == hold);
    end
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_cmd_ready", 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    int a0, a1, n, lat;
    logic [31:0] rd;
    logic er;

    tbl[0] = '{1'b1, 32'h4000_0000, 32'h0000_00A5, 0, 1'b0, 32'h1234_5678, 0, 1'b0, 3, 32'h0, 1'b0};
    tbl[1] = '{1'b0, 32'h4000_0000, 32'h0,          3, 1'b0, 32'h0000_00A5, 0, 1'b0, 6, 32'h0000_00A5, 1'b0};
    tbl[2] = '{1'b0, 32'h4000_0008, 32'h0,          1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 4, 32'h0, 1'b1};
    tbl[3] = '{1'b1, 32'h4000_000C, 32'h5555_AAAA, 2, 1'b1, 32'h7777_7777, 1, 1'b0, 5, 32'h0, 1'b1};
    tbl[4] = '{1'b0, 32'h4000_0010, 32'h0,          0, 1'b0, 32'hCAFE_F00D, 5, 1'b1, 3, 32'hCAFE_F00D, 1'b0};
    tbl[5] = '{1'b0, 32'h4000_0004, 32'h0,          0, 1'b0, 32'h5A5A_5A5A, 0, 1'b0, 3, 32'h5A5A_5A5A, 1'b0};
    tbl[6] = '{1'b0, 32'h4000_0020, 32'h0,         15, 1'b0, 32'h0BAD_F00D, 2, 1'b0, 18, 32'h0BAD_F00D, 1'b0};

    PRESET = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hFFFF_FFFF;
    cmd_wdata = 32'hFFFF_FFFF; rsp_ready = 1'b0; PRDATA = 32'h0; PREADY = 1'b1; PSLVERR = 1'b0;
    repeat (3) tick();
    reset_checks();
    PRESET = 1'b0; cmd_valid = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, tbl[i].serr, tbl[i].sdata,
           tbl[i].hold, tbl[i].keep, tbl[i].lat, tbl[i].rdata, tbl[i].err, a0);
    end

    // back-to-back zero-wait commands with rsp_ready high
    xfer(1'b1, 32'h4000_0100, 32'h0000_0001, 0, 1'b0, 32'h0, 0, 1'b0, 3, 32'h0, 1'b0, a0);
    xfer(1'b1, 32'h4000_0104, 32'h0000_0002, 0, 1'b0, 32'h0, 0, 1'b0, 3, 32'h0, 1'b0, a1);
    chk("b2b_spacing", 64'(a1 - a0), 64'(4));

    // reset in the second ACCESS wait cycle
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0040; cmd_wdata = 32'h1357_9BDF;
    PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_access1", 64'(PENABLE), 64'(1));
    tick();
    chk("mid_access2", 64'(PENABLE), 64'(1));
    chk("mid_paddr", 64'(PADDR), 64'(32'h4000_0040));
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    reset_checks();
    tick();
    chk("post_rst_psel", 64'(PSEL), 64'(0));
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    xfer(1'b0, 32'h4000_0044, 32'h0, 0, 1'b0, 32'h2468_ACE0, 0, 1'b0, 3, 32'h2468_ACE0, 1'b0, a0);

`ifdef APB_MASTER_TIMEOUT_EN
    xfer(1'b0, 32'h4000_0050, 32'h0, TMO, 1'b0, 32'h1111_2222, 0, 1'b0, 2 + TMO, 32'h0, 1'b1, a0);
    xfer(1'b1, 32'h4000_0054, 32'hABCD_0000, 40, 1'b0, 32'h0, 1, 1'b0, 2 + TMO, 32'h0, 1'b1, a0);
`else
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0050; PREADY = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    n = 0;
    for (int i = 0; i < 110; i++) begin
      if (PSEL && PENABLE && !rsp_valid) n++;
      PREADY = 1'b0;
      tick();
    end
    chk("access_persist", 64'(n), 64'(110));
    PREADY = 1'b1; PRDATA = 32'h0000_0077; PSLVERR = 1'b0;
    tick();
    chk("late_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("late_rsp_rdata", 64'(rsp_rdata), 64'(32'h77));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      logic        wr, se;
      logic [31:0] ad, wd, sd;
      int          w, hd;
      wr = 1'($urandom_range(0, 1));
      ad = $urandom; wd = $urandom; sd = $urandom;
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 18) : $urandom_range(0, 4);
      se = ($urandom_range(0, 3) == 0);
      hd = $urandom_range(0, 3);
      model(wr, w, se, sd, lat, rd, er);
      xfer(wr, ad, wd, w, se, sd, hd, 1'($urandom_range(0, 1)), lat, rd, er, a0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
